// File: rtl/put_get_channel_ctrl_pkg.sv
// Shared types for the put/get channel execution unit.
// Holds XLEN, the put/get fn3 encoding, exception codes and FSM states.
package put_get_channel_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        PG_PUT = 3'b000,
        PG_GET = 3'b001
    } put_get_arith_t;

    typedef enum logic [4:0] {
        EXC_NONE         = 5'd0,
        EXC_ILLEGAL_INST = 5'd2,
        EXC_LOAD_FAULT   = 5'd5
    } exception_code_t;

    typedef enum logic [1:0] {
        PG_IDLE,
        PG_GET_WAIT,
        PG_WB
    } pg_state_t;

endpackage

// File: rtl/put_get_channel_ctrl_if.sv
// Bundle of issue, writeback, outbound and inbound channel signals.
// slave: the put/get unit; master: issue/writeback/channel peers.
interface put_get_channel_ctrl_if #(
    parameter int ID_W = 3
);
    import put_get_channel_ctrl_pkg::*;

    logic            issue_valid;
    logic            issue_ready;
    logic [2:0]      issue_fn3;
    logic [XLEN-1:0] issue_rs1;
    logic [ID_W-1:0] issue_id;

    logic            wb_valid;
    logic            wb_ack;
    logic [ID_W-1:0] wb_id;
    logic            wb_rd_we;
    logic [XLEN-1:0] wb_data;
    logic            wb_exc;
    logic [4:0]      wb_exc_code;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_data;

    modport slave (
        input  issue_valid, issue_fn3, issue_rs1, issue_id,
        output issue_ready,
        input  wb_ack,
        output wb_valid, wb_id, wb_rd_we, wb_data, wb_exc, wb_exc_code,
        input  out_ready,
        output out_valid, out_data,
        input  in_valid, in_data,
        output in_ready
    );

    modport master (
        output issue_valid, issue_fn3, issue_rs1, issue_id,
        input  issue_ready,
        output wb_ack,
        input  wb_valid, wb_id, wb_rd_we, wb_data, wb_exc, wb_exc_code,
        output out_ready,
        input  out_valid, out_data,
        output in_valid, in_data,
        input  in_ready
    );

endinterface

// File: rtl/put_get_channel_ctrl_fifo.sv
// put_get_fifo: synchronous FIFO, no write-to-read bypass.
// Ports: clk, rst, push/din, pop, full, empty, head (0 when empty).
module put_get_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= din;
        end
    end

    // Pointers wrap naturally; count is kept separately for full/empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/put_get_channel_ctrl.sv
// Put/get execution unit: one op in flight, FIFO-buffered channels.
// Ports: clk, rst, bus (issue, writeback, out and in channels).
// Optional PUT_GET_TIMEOUT_EN bounds the get wait with LOAD_FAULT.
module put_get_channel_ctrl
    import put_get_channel_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 3
`ifdef PUT_GET_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input logic                  clk,
    input logic                  rst,
    put_get_channel_ctrl_if.slave bus
);
    pg_state_t       state_q;
    pg_state_t       state_d;
    logic [ID_W-1:0] pend_id_q;

    logic            wb_valid_q;
    logic [ID_W-1:0] wb_id_q;
    logic            wb_rd_we_q;
    logic [XLEN-1:0] wb_data_q;
    logic            wb_exc_q;
    logic [4:0]      wb_code_q;

    logic            ld;
    logic [ID_W-1:0] ld_id;
    logic            ld_rd_we;
    logic [XLEN-1:0] ld_data;
    logic            ld_exc;
    exception_code_t ld_code;
    logic            pend_ld;

    logic            out_full, out_empty;
    logic            in_full, in_empty;
    logic [XLEN-1:0] out_head, in_head;
    logic            out_push, out_pop;
    logic            in_push, in_pop;
    logic            is_put, is_get, accept;
    logic            to_hit;

    assign is_put = bus.issue_fn3 == PG_PUT;
    assign is_get = bus.issue_fn3 == PG_GET;

    assign bus.issue_ready = !rst && state_q == PG_IDLE
                           && !(is_put && out_full);
    assign accept = bus.issue_valid && bus.issue_ready;

    assign bus.in_ready  = !rst && !in_full;
    assign in_push       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = !out_empty;
    assign bus.out_data  = out_head;
    assign out_pop       = bus.out_valid && bus.out_ready;

    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_id       = wb_id_q;
    assign bus.wb_rd_we    = wb_rd_we_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_exc      = wb_exc_q;
    assign bus.wb_exc_code = wb_code_q;

    always_comb begin
        state_d  = state_q;
        ld       = 1'b0;
        ld_id    = pend_id_q;
        ld_rd_we = 1'b0;
        ld_data  = '0;
        ld_exc   = 1'b0;
        ld_code  = EXC_NONE;
        pend_ld  = 1'b0;
        in_pop   = 1'b0;
        out_push = 1'b0;
        case (state_q)
            PG_IDLE: begin
                if (accept) begin
                    ld_id = bus.issue_id;
                    if (is_put) begin
                        out_push = 1'b1;
                        ld       = 1'b1;
                        state_d  = PG_WB;
                    end else if (is_get) begin
                        if (!in_empty) begin
                            in_pop   = 1'b1;
                            ld       = 1'b1;
                            ld_rd_we = 1'b1;
                            ld_data  = in_head;
                            state_d  = PG_WB;
                        end else begin
                            pend_ld = 1'b1;
                            state_d = PG_GET_WAIT;
                        end
                    end else begin
                        ld      = 1'b1;
                        ld_exc  = 1'b1;
                        ld_code = EXC_ILLEGAL_INST;
                        state_d = PG_WB;
                    end
                end
            end
            PG_GET_WAIT: begin
                if (!in_empty) begin
                    in_pop   = 1'b1;
                    ld       = 1'b1;
                    ld_rd_we = 1'b1;
                    ld_data  = in_head;
                    state_d  = PG_WB;
                end else if (to_hit) begin
                    ld      = 1'b1;
                    ld_exc  = 1'b1;
                    ld_code = EXC_LOAD_FAULT;
                    state_d = PG_WB;
                end
            end
            PG_WB: begin
                if (bus.wb_ack) state_d = PG_IDLE;
            end
            default: state_d = PG_IDLE;
        endcase
    end

`ifdef PUT_GET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive cycle spent waiting.
    assign to_hit = to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q == PG_GET_WAIT
                     && state_d == PG_GET_WAIT) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PG_IDLE;
            pend_id_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_id_q    <= '0;
            wb_rd_we_q <= 1'b0;
            wb_data_q  <= '0;
            wb_exc_q   <= 1'b0;
            wb_code_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pend_ld) pend_id_q <= bus.issue_id;
            if (ld) begin
                wb_valid_q <= 1'b1;
                wb_id_q    <= ld_id;
                wb_rd_we_q <= ld_rd_we;
                wb_data_q  <= ld_data;
                wb_exc_q   <= ld_exc;
                wb_code_q  <= ld_code;
            end else if (state_q == PG_WB && bus.wb_ack) begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    put_get_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (XLEN)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_push),
        .din   (bus.issue_rs1),
        .pop   (out_pop),
        .full  (out_full),
        .empty (out_empty),
        .head  (out_head)
    );

    put_get_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (XLEN)
    ) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_push),
        .din   (bus.in_data),
        .pop   (in_pop),
        .full  (in_full),
        .empty (in_empty),
        .head  (in_head)
    );

endmodule

// File: tb/tb_put_get_channel_ctrl.sv
// Bench for put_get_channel_ctrl: directed scenarios plus random
// traffic, checked every cycle against a queue-based model.
module tb_put_get_channel_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 1024;
    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_WB    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    put_get_channel_ctrl_if #(.ID_W(3)) bus ();

    put_get_channel_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .ID_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mq_out[$];
    logic [31:0] mq_in[$];
    int          mode = M_IDLE;
    int          wait_cnt = 0;
    logic [2:0]  pid;
    logic [2:0]  e_id;
    logic        e_we;
    logic [31:0] e_data;
    logic        e_exc;
    logic [4:0]  e_code;
    bit          issue_acc;
    bit          in_acc;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_wb(logic [2:0] id, logic we, logic [31:0] d,
                          logic exc, logic [4:0] code);
        mode   = M_WB;
        e_id   = id;
        e_we   = we;
        e_data = d;
        e_exc  = exc;
        e_code = code;
    endtask

    // One clock: check outputs at negedge, advance model, end at posedge+1.
    task automatic tick();
        bit          exp_ov, exp_inr, exp_ir, out_pop, in_push;
        logic [31:0] exp_od, in_d;
        @(negedge clk);
        if (rst) begin
            mq_out.delete();
            mq_in.delete();
            mode     = M_IDLE;
            wait_cnt = 0;
        end
        exp_ov  = mq_out.size() > 0;
        exp_od  = exp_ov ? mq_out[0] : 32'd0;
        exp_inr = !rst && mq_in.size() < DEPTH;
        exp_ir  = !rst && mode == M_IDLE
                  && !(bus.issue_fn3 == 3'b000 && mq_out.size() == DEPTH);
        chk("issue_ready", bus.issue_ready, exp_ir);
        chk("out_valid", bus.out_valid, exp_ov);
        chk("out_data", bus.out_data, exp_od);
        chk("in_ready", bus.in_ready, exp_inr);
        chk("wb_valid", bus.wb_valid, mode == M_WB);
        if (mode == M_WB) begin
            chk("wb_id", bus.wb_id, e_id);
            chk("wb_rd_we", bus.wb_rd_we, e_we);
            chk("wb_data", bus.wb_data, e_data);
            chk("wb_exc", bus.wb_exc, e_exc);
            chk("wb_exc_code", bus.wb_exc_code, e_code);
        end
        out_pop   = exp_ov && bus.out_ready;
        in_push   = bus.in_valid && exp_inr;
        in_d      = bus.in_data;
        issue_acc = bus.issue_valid && exp_ir;
        in_acc    = in_push;
        if (!rst) begin
            if (out_pop) void'(mq_out.pop_front());
            if (mode == M_IDLE && issue_acc) begin
                pid = bus.issue_id;
                if (bus.issue_fn3 == 3'b000) begin
                    mq_out.push_back(bus.issue_rs1);
                    set_wb(pid, 1'b0, 32'd0, 1'b0, 5'd0);
                end else if (bus.issue_fn3 == 3'b001) begin
                    if (mq_in.size() > 0) begin
                        set_wb(pid, 1'b1, mq_in.pop_front(), 1'b0, 5'd0);
                    end else begin
                        mode     = M_WAIT;
                        wait_cnt = 0;
                    end
                end else begin
                    set_wb(pid, 1'b0, 32'd0, 1'b1, 5'd2);
                end
            end else if (mode == M_WAIT) begin
                if (mq_in.size() > 0) begin
                    set_wb(pid, 1'b1, mq_in.pop_front(), 1'b0, 5'd0);
                end else begin
                    wait_cnt++;
`ifdef PUT_GET_TIMEOUT_EN
                    if (wait_cnt == TIMEOUT) begin
                        set_wb(pid, 1'b0, 32'd0, 1'b1, 5'd5);
                    end
`endif
                end
            end else if (mode == M_WB && bus.wb_ack) begin
                mode = M_IDLE;
            end
            if (in_push) mq_in.push_back(in_d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_issue(logic [2:0] f, logic [31:0] d, logic [2:0] id);
        int n = 0;
        bus.issue_valid = 1'b1;
        bus.issue_fn3   = f;
        bus.issue_rs1   = d;
        bus.issue_id    = id;
        issue_acc       = 1'b0;
        while (!issue_acc && n < 50) begin
            tick();
            n++;
        end
        chk("issue_accepted", {31'd0, issue_acc}, 32'd1);
        bus.issue_valid = 1'b0;
    endtask

    task automatic push_in(logic [31:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        in_acc       = 1'b0;
        while (!in_acc && n < 50) begin
            tick();
            n++;
        end
        chk("in_accepted", {31'd0, in_acc}, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_fn3   = 3'b000;
        bus.issue_rs1   = '0;
        bus.issue_id    = '0;
        bus.wb_ack      = 1'b1;
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;

        // Reset state: every output low.
        run(2);
        chk("rst_wb_id", bus.wb_id, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_exc", bus.wb_exc, 32'd0);
        chk("rst_in_ready", bus.in_ready, 32'd0);
        rst = 1'b0;
        run(2);

        // Single put with the outbound side ready.
        bus.out_ready = 1'b1;
        do_issue(3'b000, 32'hDEADBEEF, 3'd1);
        chk("put_wb_valid", bus.wb_valid, 32'd1);
        chk("put_out_data", bus.out_data, 32'hDEADBEEF);
        run(3);

        // Fill the outbound FIFO, then the fifth put must stall.
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            do_issue(3'b000, 32'h100 + i, 3'(i));
        end
        bus.issue_valid = 1'b1;
        bus.issue_fn3   = 3'b000;
        bus.issue_rs1   = 32'h555;
        run(3);
        chk("put_full_stall", bus.issue_ready, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        do_issue(3'b000, 32'h555, 3'd5);
        bus.out_ready = 1'b1;
        run(8);

        // Get on empty inbound, data arrives ten cycles later.
        do_issue(3'b001, 32'd0, 3'd6);
        run(10);
        chk("get_wait_no_wb", bus.wb_valid, 32'd0);
        push_in(32'h1234);
        run(3);

        // Push and pop in the same cycle with two entries buffered.
        push_in(32'hA0);
        push_in(32'hB0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hC0;
        do_issue(3'b001, 32'd0, 3'd2);
        chk("same_cycle_push", {31'd0, in_acc}, 32'd1);
        bus.in_valid = 1'b0;
        do_issue(3'b001, 32'd0, 3'd3);
        do_issue(3'b001, 32'd0, 3'd4);
        run(2);

        // Reserved fn3 leaves the FIFOs alone.
        do_issue(3'b101, 32'hFFFF, 3'd7);
        chk("illegal_code", bus.wb_exc_code, 32'd2);
        run(2);

        // Reset while waiting on a get with outbound data held.
        bus.out_ready = 1'b0;
        do_issue(3'b000, 32'h77, 3'd1);
        do_issue(3'b001, 32'd0, 3'd2);
        run(3);
        rst = 1'b1;
        tick();
        chk("rst_mid_wb_valid", bus.wb_valid, 32'd0);
        chk("rst_mid_out_valid", bus.out_valid, 32'd0);
        rst = 1'b0;
        run(2);

`ifdef PUT_GET_TIMEOUT_EN
        begin
            int n = 0;
            do_issue(3'b001, 32'd0, 3'd3);
            while (mode != M_WB && n < TIMEOUT + 20) begin
                tick();
                n++;
            end
            chk("timeout_reached", {31'd0, mode == M_WB}, 32'd1);
            chk("timeout_code", bus.wb_exc_code, 32'd5);
            run(2);
        end
`endif

        // Random traffic with randomized back-pressure and acks.
        for (int c = 0; c < 3000; c++) begin
            if (!bus.issue_valid && $urandom_range(0, 2) == 0) begin
                int r;
                r = $urandom_range(0, 19);
                bus.issue_valid = 1'b1;
                bus.issue_fn3   = r < 9 ? 3'b000 :
                                  r < 18 ? 3'b001 :
                                  3'($urandom_range(2, 7));
                bus.issue_rs1   = $urandom;
                bus.issue_id    = 3'($urandom_range(0, 7));
            end
            if (!bus.in_valid && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = $urandom;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.wb_ack    = $urandom_range(0, 3) != 0;
            tick();
            if (issue_acc) bus.issue_valid = 1'b0;
            if (in_acc) bus.in_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
